embedding_vector_loader: RTL and testbench



---
 rtl/embedding_pkg.sv | 56 +++++
 rtl/evl_frame_bank.sv | 70 +++++++
 rtl/embedding_vector_loader.sv | 152 +++++++++++++++
 tb/tb_embedding_vector_loader.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/embedding_pkg.sv
// ----------------------------------------------------------------------------
// embedding_pkg
//   Shared definitions for the embedding loader and the dot-product stage.
//   Holds the frame geometry, the per-beat element record and the packed
//   frame layout that the loader presents to its consumer.
//   Also classifies an input beat by how it affects the frame being filled.
// ----------------------------------------------------------------------------
package embedding_pkg;

  localparam int N_ELEM  = 10;                      // elements per frame
  localparam int MAG_W   = 4;                       // magnitude bits per element
  localparam int IDX_W   = $clog2(N_ELEM);          // slot index width
  localparam int VEC_W   = N_ELEM * MAG_W;          // packed magnitude vector width
  localparam int ELEM_W  = 2 * MAG_W + 2;           // one element record
  localparam int FRAME_W = 2 * VEC_W + 2 * N_ELEM;  // one complete frame

  typedef logic [MAG_W-1:0] mag_t;

  typedef struct packed {
    mag_t mag_a;
    mag_t mag_b;
    logic sign_a;
    logic sign_b;
  } elem_t;

  // Element i magnitude lives at [MAG_W*i +: MAG_W]; element i sign at bit i.
  typedef struct packed {
    logic [VEC_W-1:0]  vec_a;
    logic [VEC_W-1:0]  vec_b;
    logic [N_ELEM-1:0] vec_c;
    logic [N_ELEM-1:0] vec_d;
  } frame_t;

  // How an accepted beat relates to the frame under construction.
  typedef enum logic [1:0] {
    BEAT_NONE  = 2'd0,  // no beat, or a mid-frame beat
    BEAT_FULL  = 2'd1,  // beat fills the last slot
    BEAT_SHORT = 2'd2   // in_last arrives before the last slot
  } beat_kind_t;

  function automatic beat_kind_t classify_beat(input logic             accept,
                                               input logic [IDX_W-1:0] idx,
                                               input logic             last);
    beat_kind_t kind;
    kind = BEAT_NONE;
    if (accept) begin
      if (idx == IDX_W'(N_ELEM - 1)) begin
        kind = BEAT_FULL;
      end else if (last) begin
        kind = BEAT_SHORT;
      end
    end
    return kind;
  endfunction

endpackage

// File: rtl/evl_frame_bank.sv
// ----------------------------------------------------------------------------
// evl_frame_bank
//   Storage for one frame of embedding elements. Each slot is written
//   individually; when pad_en_i accompanies a write, every slot above the
//   written one is cleared in the same cycle (zero padding of short frames).
//   The whole frame is read in parallel.
// Ports
//   clk        in  clock, rising edge
//   rst        in  asynchronous active-high reset, clears all slots
//   wr_en_i    in  write the element into slot wr_idx_i
//   wr_idx_i   in  target slot
//   wr_elem_i  in  element record (elem_t layout)
//   pad_en_i   in  with wr_en_i: clear slots wr_idx_i+1 .. N_ELEM-1
//   frame_o    out stored frame (frame_t layout)
// ----------------------------------------------------------------------------
module evl_frame_bank
  import embedding_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic [ELEM_W-1:0]  wr_elem_i,
  input  logic               pad_en_i,
  output logic [FRAME_W-1:0] frame_o
);

  elem_t wr_elem;
  assign wr_elem = elem_t'(wr_elem_i);

  logic [VEC_W-1:0]  vec_a;
  logic [VEC_W-1:0]  vec_b;
  logic [N_ELEM-1:0] vec_c;
  logic [N_ELEM-1:0] vec_d;

  genvar gi;
  generate
    for (gi = 0; gi < N_ELEM; gi++) begin : g_slot
      elem_t slot_q;
      elem_t slot_d;

      always_comb begin
        slot_d = slot_q;
        if (wr_en_i) begin
          if (wr_idx_i == IDX_W'(gi)) begin
            slot_d = wr_elem;
          end else if (pad_en_i && (wr_idx_i < IDX_W'(gi))) begin
            slot_d = '0;
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          slot_q <= '0;
        end else begin
          slot_q <= slot_d;
        end
      end

      assign vec_a[MAG_W*gi +: MAG_W] = slot_q.mag_a;
      assign vec_b[MAG_W*gi +: MAG_W] = slot_q.mag_b;
      assign vec_c[gi]                = slot_q.sign_a;
      assign vec_d[gi]                = slot_q.sign_b;
    end
  endgenerate

  assign frame_o = {vec_a, vec_b, vec_c, vec_d};

endmodule

// File: rtl/embedding_vector_loader.sv
// ----------------------------------------------------------------------------
// embedding_vector_loader
//   Packs N_ELEM input beats (magnitude + sign for parties A and B) into one
//   frame and presents complete frames to the dot-product stage over a
//   valid/ready handshake. Two banks ping-pong: one fills while the other is
//   held for the consumer.
// Build option
//   EVL_ZERO_PAD_EN  defined  : a short frame (in_last early) is closed, the
//                               remaining slots zero-filled, no error.
//                    undefined: a short frame is discarded and err_framing
//                               pulses.
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   in_valid / in_ready      input beat handshake
//   in_mag_a, in_mag_b       party magnitudes (unsigned)
//   in_sign_a, in_sign_b     party sign bits
//   in_last                  final beat of a frame
//   out_valid / out_ready    frame handshake
//   vector_a, vector_b       packed magnitudes of the presented frame
//   vector_c, vector_d       sign bits of the presented frame
//   err_framing              one-cycle pulse on a framing violation
// ----------------------------------------------------------------------------
module embedding_vector_loader
  import embedding_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MAG_W-1:0]         in_mag_a,
  input  logic [MAG_W-1:0]         in_mag_b,
  input  logic                     in_sign_a,
  input  logic                     in_sign_b,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_ELEM*MAG_W-1:0]  vector_a,
  output logic [N_ELEM*MAG_W-1:0]  vector_b,
  output logic [N_ELEM-1:0]        vector_c,
  output logic [N_ELEM-1:0]        vector_d,
  output logic                     err_framing
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       full_cnt_q, full_cnt_d;
  logic             err_q, err_d;

  logic       accept;
  logic       pop;
  logic       publish;
  logic       pad_en;
  beat_kind_t beat_kind;
  elem_t      beat;

  assign in_ready  = (full_cnt_q != 2'd2);
  assign out_valid = (full_cnt_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign beat_kind = classify_beat(accept, idx_q, in_last);

  assign beat = '{mag_a: in_mag_a, mag_b: in_mag_b, sign_a: in_sign_a, sign_b: in_sign_b};

  // Frame closing policy. A full frame is always published; a missing in_last
  // on the closing beat is reported but does not drop the data.
`ifdef EVL_ZERO_PAD_EN
  assign publish = (beat_kind == BEAT_FULL) || (beat_kind == BEAT_SHORT);
  assign pad_en  = (beat_kind == BEAT_SHORT);
  assign err_d   = (beat_kind == BEAT_FULL) && !in_last;
`else
  assign publish = (beat_kind == BEAT_FULL);
  assign pad_en  = 1'b0;
  assign err_d   = ((beat_kind == BEAT_FULL) && !in_last) || (beat_kind == BEAT_SHORT);
`endif

  always_comb begin
    idx_d      = idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    full_cnt_d = full_cnt_q;

    if (accept) begin
      // Any frame end (published or discarded) restarts filling at slot 0.
      if (beat_kind != BEAT_NONE) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    if (publish) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    // Simultaneous publish and pop leaves the occupancy unchanged.
    case ({publish, pop})
      2'b10:   full_cnt_d = full_cnt_q + 2'd1;
      2'b01:   full_cnt_d = full_cnt_q - 2'd1;
      default: full_cnt_d = full_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      full_cnt_q <= 2'd0;
      err_q      <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      full_cnt_q <= full_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_framing = err_q;

  // Ping-pong banks. in_ready guarantees the write bank is never the bank
  // being held for the consumer while it is full.
  logic [FRAME_W-1:0] bank_frame [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      evl_frame_bank u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (accept && (wr_ptr_q == 1'(gi))),
        .wr_idx_i  (idx_q),
        .wr_elem_i (beat),
        .pad_en_i  (pad_en),
        .frame_o   (bank_frame[gi])
      );
    end
  endgenerate

  frame_t rd_frame;
  assign rd_frame = bank_frame[rd_ptr_q];

  assign vector_a = rd_frame.vec_a;
  assign vector_b = rd_frame.vec_b;
  assign vector_c = rd_frame.vec_c;
  assign vector_d = rd_frame.vec_d;

endmodule

// File: tb/tb_embedding_vector_loader.sv
// ----------------------------------------------------------------------------
// Testbench for embedding_vector_loader. A reference model of the frame
// assembly pushes expected frames into a scoreboard as beats are accepted;
// frames are checked while presented and popped when the consumer takes them.
// ----------------------------------------------------------------------------
module tb_embedding_vector_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_mag_a = '0;
  logic [3:0]  in_mag_b = '0;
  logic        in_sign_a = 1'b0;
  logic        in_sign_b = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [39:0] vector_a;
  logic [39:0] vector_b;
  logic [9:0]  vector_c;
  logic [9:0]  vector_d;
  logic        err_framing;

  embedding_vector_loader dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mag_a    (in_mag_a),
    .in_mag_b    (in_mag_b),
    .in_sign_a   (in_sign_a),
    .in_sign_b   (in_sign_b),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .vector_a    (vector_a),
    .vector_b    (vector_b),
    .vector_c    (vector_c),
    .vector_d    (vector_d),
    .err_framing (err_framing)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [3:0]  m_a  [10];
  logic [3:0]  m_b  [10];
  logic        m_sa [10];
  logic        m_sb [10];
  int          m_idx   = 0;
  int          m_full  = 0;
  logic        exp_err = 1'b0;
  logic [99:0] sb_q [$];

  function automatic logic [99:0] model_frame();
    logic [39:0] fa, fb;
    logic [9:0]  fc, fd;
    for (int i = 0; i < 10; i++) begin
      fa[4*i +: 4] = m_a[i];
      fb[4*i +: 4] = m_b[i];
      fc[i]        = m_sa[i];
      fd[i]        = m_sb[i];
    end
    return {fa, fb, fc, fd};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 10; i++) begin
      m_a[i] = '0; m_b[i] = '0; m_sa[i] = 1'b0; m_sb[i] = 1'b0;
    end
    m_idx   = 0;
    m_full  = 0;
    exp_err = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_accept();
    m_a[m_idx]  = in_mag_a;
    m_b[m_idx]  = in_mag_b;
    m_sa[m_idx] = in_sign_a;
    m_sb[m_idx] = in_sign_b;
    if (m_idx == 9) begin
      sb_q.push_back(model_frame());
      m_full++;
      exp_err = !in_last;
      m_idx   = 0;
    end else if (in_last) begin
`ifdef EVL_ZERO_PAD_EN
      for (int k = m_idx + 1; k < 10; k++) begin
        m_a[k] = '0; m_b[k] = '0; m_sa[k] = 1'b0; m_sb[k] = 1'b0;
      end
      sb_q.push_back(model_frame());
      m_full++;
`else
      exp_err = 1'b1;
`endif
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  // One clock cycle: check the presented state at the falling edge, advance
  // the model by whatever handshakes complete at the next rising edge.
  task automatic tick();
    logic        acc, pp;
    logic [99:0] obs;
    @(negedge clk);
    obs = {vector_a, vector_b, vector_c, vector_d};
    compared++;
    if (out_valid !== (m_full != 0)) begin
      mismatched++;
      $display("FAIL out_valid: got %b expected %b", out_valid, (m_full != 0));
    end
    compared++;
    if (in_ready !== (m_full != 2)) begin
      mismatched++;
      $display("FAIL in_ready: got %b expected %b", in_ready, (m_full != 2));
    end
    compared++;
    if (err_framing !== exp_err) begin
      mismatched++;
      $display("FAIL err_framing: got %b expected %b", err_framing, exp_err);
    end
    if (m_full != 0 && sb_q.size() > 0) begin
      compared++;
      if (obs !== sb_q[0]) begin
        mismatched++;
        $display("FAIL frame_data: got %h expected %h", obs, sb_q[0]);
      end
    end
    acc     = in_valid && (m_full != 2);
    pp      = out_ready && (m_full != 0);
    exp_err = 1'b0;
    if (pp) begin
      $display("pop   frame %h", sb_q[0]);
      void'(sb_q.pop_front());
      m_full--;
    end
    if (acc) begin
      $display("beat  idx=%0d a=%h b=%h sa=%b sb=%b last=%b",
               m_idx, in_mag_a, in_mag_b, in_sign_a, in_sign_b, in_last);
      model_accept();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [3:0] ma, input logic [3:0] mb,
                           input logic sa, input logic sb, input logic last);
    int guard;
    in_valid  = 1'b1;
    in_mag_a  = ma;
    in_mag_b  = mb;
    in_sign_a = sa;
    in_sign_b = sb;
    in_last   = last;
    guard = 0;
    while (m_full == 2 && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) begin
      compared++;
      mismatched++;
      $display("FAIL beat_stall: in_ready never returned within %0d cycles", guard);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_random(input int n, input logic last_on_final);
    for (int i = 0; i < n; i++) begin
      send_beat(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                last_on_final && (i == n - 1));
    end
  endtask

  task automatic drain();
    int guard;
    out_ready = 1'b1;
    guard = 0;
    while (sb_q.size() > 0 && guard < 100) begin
      tick();
      guard++;
    end
    tick();
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL drain: out_valid got %b expected 0 after %0d cycles", out_valid, guard);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    #12;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || err_framing !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b err=%b expected 1 0 0",
               in_ready, out_valid, err_framing);
    end
    compared++;
    if ({vector_a, vector_b, vector_c, vector_d} !== 100'd0) begin
      mismatched++;
      $display("FAIL reset_vectors: got %h expected 0", {vector_a, vector_b, vector_c, vector_d});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_frame();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_beat(4'(i), 4'd2, 1'b0, 1'b0, i == 9);
    end
    compared++;
    if (out_valid !== 1'b1 || vector_a !== 40'h9876543210 || vector_b !== 40'h2222222222 ||
        vector_c !== 10'd0 || vector_d !== 10'd0 || err_framing !== 1'b0) begin
      mismatched++;
      $display("FAIL single_frame: valid=%b a=%h b=%h c=%h d=%h err=%b expected 1 9876543210 2222222222 0 0 0",
               out_valid, vector_a, vector_b, vector_c, vector_d, err_framing);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [99:0] first;
    out_ready = 1'b0;
    send_random(10, 1'b1);
    first = {vector_a, vector_b, vector_c, vector_d};
    send_random(10, 1'b1);
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL backpressure: in_ready got %b expected 0", in_ready);
    end
    // Hold a third frame's first beat against backpressure for a few cycles.
    in_valid = 1'b1;
    in_mag_a = 4'hF;
    in_mag_b = 4'hF;
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    compared++;
    if ({vector_a, vector_b, vector_c, vector_d} !== sb_q[0] || sb_q[0] !== first) begin
      mismatched++;
      $display("FAIL hold_stable: got %h expected %h", {vector_a, vector_b, vector_c, vector_d}, first);
    end
    out_ready = 1'b1;
    send_random(10, 1'b1);
    drain();
  endtask

  task automatic test_pop_and_close();
    out_ready = 1'b0;
    send_random(10, 1'b1);
    send_random(9, 1'b0);
    out_ready = 1'b1;
    send_beat(4'hA, 4'h5, 1'b1, 1'b0, 1'b1);
    compared++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL pop_close: out_valid=%b in_ready=%b expected 1 1", out_valid, in_ready);
    end
    out_ready = 1'b0;
    tick();
    drain();
  endtask

  task automatic test_short_frame();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_beat(4'(5 + i), 4'(1 + i), 1'b1, 1'b1, i == 3);
    end
`ifdef EVL_ZERO_PAD_EN
    compared++;
    if (out_valid !== 1'b1 || vector_a !== 40'h0000008765 || vector_b !== 40'h0000004321 ||
        vector_c !== 10'h00F || vector_d !== 10'h00F || err_framing !== 1'b0) begin
      mismatched++;
      $display("FAIL short_pad: valid=%b a=%h b=%h c=%h d=%h err=%b",
               out_valid, vector_a, vector_b, vector_c, vector_d, err_framing);
    end
`else
    compared++;
    if (out_valid !== 1'b0 || err_framing !== 1'b1) begin
      mismatched++;
      $display("FAIL short_discard: out_valid=%b err=%b expected 0 1", out_valid, err_framing);
    end
`endif
    send_random(10, 1'b1);
    drain();
  endtask

  task automatic test_missing_last();
    out_ready = 1'b0;
    send_random(10, 1'b0);
    compared++;
    if (out_valid !== 1'b1 || err_framing !== 1'b1) begin
      mismatched++;
      $display("FAIL missing_last: out_valid=%b err=%b expected 1 1", out_valid, err_framing);
    end
    drain();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send_random(10, 1'b1);
    send_random(6, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_framing !== 1'b0 ||
        {vector_a, vector_b, vector_c, vector_d} !== 100'd0) begin
      mismatched++;
      $display("FAIL async_reset: out_valid=%b in_ready=%b err=%b vec=%h",
               out_valid, in_ready, err_framing, {vector_a, vector_b, vector_c, vector_d});
    end
    model_reset();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_beat(4'(9 - i), 4'(i), i[0], !i[0], i == 9);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_pop_and_close();
    test_short_frame();
    test_missing_last();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
